mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_arith.sv | 64 ++++++
 rtl/mult_div_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared MD-unit opcode and FSM state encodings, plus small opcode classifiers
// used by the control decoder, the arithmetic core and the sequencing block.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Multi-cycle operations: these occupy the unit and commit through the FSM.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide core: signed/unsigned product into {hi,lo},
// quotient into lo and remainder into hi for the divide opcodes.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    prod_s;
    logic [W2-1:0]    prod_u;
    logic             signed_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    always_comb begin
        // NOTE: every output of this block gets a value before the case below,
        // so no path leaves a signal unassigned and no latch is inferred.
        hi          = '0;
        lo          = '0;
        div_by_zero = 1'b0;

        // Low 2*WIDTH bits of a product of sign-extended operands equal the
        // signed product, so one unsigned multiplier form serves both.
        prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

        // Signed divide works on magnitudes; -2^(W-1) / -1 falls out as the
        // bit pattern 2^(W-1) with remainder 0, with no special case needed.
        signed_div = (op == MDU_DIV);
        a_neg      = signed_div & a[WIDTH-1];
        b_neg      = signed_div & b[WIDTH-1];
        a_mag      = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag      = b_neg ? (~b + WIDTH'(1)) : b;
        dvsr       = (b_mag == '0) ? WIDTH'(1) : b_mag;
        q_mag      = a_mag / dvsr;
        r_mag      = a_mag % dvsr;

        case (op)
            MDU_MULT:  {hi, lo} = prod_s;
            MDU_MULTU: {hi, lo} = prod_u;
            MDU_DIV, MDU_DIVU: begin
                div_by_zero = (b == '0);
                lo          = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
                hi          = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit: computes the result at Start, holds it
// pending for a fixed busy period, then commits it unless flushed or reset.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [3:0]       MDUOP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    mdu_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic             pend_ok_q, pend_ok_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] arith_hi;
    logic [WIDTH-1:0] arith_lo;
    logic             arith_div0;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op          (MDUOP),
        .a           (A),
        .b           (B),
        .hi          (arith_hi),
        .lo          (arith_lo),
        .div_by_zero (arith_div0)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Flush in the same cycle squashes the instruction being issued.
                if (Start && !Flush) begin
                    if (is_long_op(MDUOP)) begin
                        pend_hi_d = arith_hi;
                        pend_lo_d = arith_lo;
                        pend_ok_d = !arith_div0;
                        cnt_d     = is_div_op(MDUOP) ? DIV_CNT : MULT_CNT;
                        state_d   = ST_BUSY;
                    end else if (MDUOP == MDU_MTHI) begin
                        hi_d = A;
                    end else if (MDUOP == MDU_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_BUSY: begin
                // Start is deliberately not examined here; Flush outranks the final count.
                if (Flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (pend_ok_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the pending registers are reset as well so a stale
    // result can never be committed after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
            done_q    <= done_d;
        end
    end

    assign Busy = (state_q == ST_BUSY);
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
